// File: rtl/pll_clk_sequencer.sv
// PLL supervisor: drives the PLL reset, qualifies lock, sequences sys_rst_n and generates clock enables.
// Defining CLKSEQ_TIMEOUT_EN builds a WAIT_LOCK timeout that restarts bring-up after LOCK_TMO cycles.
module pll_clk_sequencer #(
    parameter int NUM_CH      = 3,
    parameter int DIV_W       = 8,
    parameter int PLL_RST_CYC = 16,
    parameter int LOCK_FILT   = 256,
    parameter int RST_HOLD    = 32,
    parameter int LOCK_TMO    = 65536
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    pll_lock,
    input  logic                    sw_relock,
    input  logic [NUM_CH*DIV_W-1:0] div,
    input  logic                    div_load,
    output logic                    pll_reset,
    output logic                    sys_rst_n,
    output logic                    ready,
    output logic [NUM_CH-1:0]       ce,
    output logic [7:0]              relock_cnt,
    output logic [1:0]              state
);

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } state_e;

    // One phase counter is shared by PLL_RST, WAIT_LOCK and HOLD, so size it for the longest phase.
    localparam int CNT_A   = (PLL_RST_CYC > LOCK_FILT) ? PLL_RST_CYC : LOCK_FILT;
    localparam int CNT_MAX = (CNT_A > RST_HOLD) ? CNT_A : RST_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);

    state_e                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [7:0]                      relock_q, relock_d;
    logic                            sync1_q, lock_s_q;
    logic                            tmo_hit_s;
    logic                            pll_reset_q, sys_rst_n_q, ready_q;
    logic [NUM_CH-1:0]               ce_q, ce_d;
    logic [NUM_CH-1:0][DIV_W-1:0]    shadow_q, shadow_d;
    logic [NUM_CH-1:0][DIV_W-1:0]    act_q, act_d;
    logic [NUM_CH-1:0][DIV_W-1:0]    dcnt_q, dcnt_d;
    logic                            run_stay_s;

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_lock;
            lock_s_q <= sync1_q;
        end
    end

`ifdef CLKSEQ_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(LOCK_TMO + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TMO - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    assign tmo_hit_s = (state_q == ST_WAIT_LOCK) && (tmo_q == TMO_LAST);

    // Timeout counter runs only while the FSM stays in WAIT_LOCK
    always_comb begin
        tmo_d = '0;
        if ((state_q == ST_WAIT_LOCK) && (state_d == ST_WAIT_LOCK)) begin
            tmo_d = tmo_q + TMO_W'(1);
        end else begin
            tmo_d = '0;
        end
    end

    // Timeout counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Next-state, phase counter and relock counter
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        relock_d = relock_q;
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                // Qualification wins over a timeout expiring in the same cycle.
                if (sw_relock) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                end else if (lock_s_q && (cnt_q == FILT_LAST)) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else if (tmo_hit_s) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                end else if (lock_s_q) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            ST_HOLD: begin
                if (sw_relock || !lock_s_q) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (sw_relock || !lock_s_q) begin
                    state_d = ST_PLL_RST;
                end else begin
                    state_d = ST_RUN;
                end
                cnt_d = '0;
            end
            default: begin
                state_d = ST_PLL_RST;
                cnt_d   = '0;
            end
        endcase
        if ((state_d == ST_PLL_RST) && (state_q != ST_PLL_RST) && (relock_q != 8'hFF)) begin
            relock_d = relock_q + 8'd1;
        end else begin
            relock_d = relock_q;
        end
    end

    assign run_stay_s = (state_q == ST_RUN) && (state_d == ST_RUN);

    // Per-channel dividers; a new divide value is adopted only at a wrap or while disabled
    always_comb begin
        shadow_d = shadow_q;
        act_d    = act_q;
        dcnt_d   = '0;
        ce_d     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (div_load) begin
                shadow_d[i] = div[i*DIV_W +: DIV_W];
            end else begin
                shadow_d[i] = shadow_q[i];
            end
            if (act_q[i] == '0) begin
                act_d[i]  = shadow_q[i];
                dcnt_d[i] = '0;
            end else if (run_stay_s) begin
                if (dcnt_q[i] == (act_q[i] - DIV_W'(1))) begin
                    ce_d[i]   = 1'b1;
                    dcnt_d[i] = '0;
                    act_d[i]  = shadow_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DIV_W'(1);
                end
            end else begin
                dcnt_d[i] = '0;
            end
        end
    end

    // FSM state, phase counter and registered status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_PLL_RST;
            cnt_q       <= '0;
            relock_q    <= 8'd0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            relock_q    <= relock_d;
            pll_reset_q <= (state_d == ST_PLL_RST);
            sys_rst_n_q <= (state_d == ST_RUN);
            ready_q     <= (state_d == ST_RUN);
        end
    end

    // Divider shadow, active value, counter and enable registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= '0;
            act_q    <= '0;
            dcnt_q   <= '0;
            ce_q     <= '0;
        end else begin
            shadow_q <= shadow_d;
            act_q    <= act_d;
            dcnt_q   <= dcnt_d;
            ce_q     <= ce_d;
        end
    end

    assign pll_reset  = pll_reset_q;
    assign sys_rst_n  = sys_rst_n_q;
    assign ready      = ready_q;
    assign ce         = ce_q;
    assign relock_cnt = relock_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pll_clk_sequencer.sv
// Bench for pll_clk_sequencer: directed vector table, divider/timeout/reset sequences,
// and a randomized phase checked every cycle against a behavioural model.
module tb_pll_clk_sequencer;

    localparam int NUM_CH      = 2;
    localparam int DIV_W       = 8;
    localparam int PLL_RST_CYC = 4;
    localparam int LOCK_FILT   = 8;
    localparam int RST_HOLD    = 4;
    localparam int LOCK_TMO    = 64;

    logic                    clk = 1'b0;
    logic                    reset_n, pll_lock, sw_relock, div_load;
    logic [NUM_CH*DIV_W-1:0] div;
    logic                    pll_reset, sys_rst_n, ready;
    logic [NUM_CH-1:0]       ce;
    logic [7:0]              relock_cnt;
    logic [1:0]              state;
    logic [14:0]             obs;

    int n_pass = 0;
    int n_chk  = 0;

    pll_clk_sequencer #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .PLL_RST_CYC(PLL_RST_CYC),
        .LOCK_FILT(LOCK_FILT), .RST_HOLD(RST_HOLD), .LOCK_TMO(LOCK_TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pll_lock(pll_lock), .sw_relock(sw_relock),
        .div(div), .div_load(div_load), .pll_reset(pll_reset), .sys_rst_n(sys_rst_n),
        .ready(ready), .ce(ce), .relock_cnt(relock_cnt), .state(state)
    );

    always #5 clk = ~clk;

    assign obs = {state, pll_reset, sys_rst_n, ready, ce, relock_cnt};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // ---------------- behavioural reference model ----------------
    int m_mode, m_tin, m_streak, m_wt, m_relock, m_k;
    logic m_s1, m_s2;
    int m_p[NUM_CH];
    int m_base[NUM_CH];
    int m_sh[NUM_CH];
    logic [NUM_CH-1:0] m_ce;

    task automatic m_reset();
        m_mode = 0; m_tin = 0; m_streak = 0; m_wt = 0; m_relock = 0; m_k = 0;
        m_s1 = 1'b0; m_s2 = 1'b0; m_ce = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_p[i] = 0; m_base[i] = 0; m_sh[i] = 0;
        end
    endtask

    task automatic m_step();
        logic ls;
        int   old, nxt;
        bit   restart, stay;
        int   sh_old;
        ls = m_s2; m_s2 = m_s1; m_s1 = pll_lock;
        old = m_mode; nxt = old; restart = 1'b0;
        case (old)
            0: begin
                m_tin++;
                if (m_tin == PLL_RST_CYC) nxt = 1;
            end
            1: begin
                if (sw_relock) restart = 1'b1;
                else begin
                    m_streak = ls ? m_streak + 1 : 0;
                    if (m_streak == LOCK_FILT) nxt = 2;
                    else begin
`ifdef CLKSEQ_TIMEOUT_EN
                        m_wt++;
                        if (m_wt == LOCK_TMO) restart = 1'b1;
`endif
                    end
                end
            end
            2: begin
                if (sw_relock || !ls) restart = 1'b1;
                else begin
                    m_tin++;
                    if (m_tin == RST_HOLD) nxt = 3;
                end
            end
            default: if (sw_relock || !ls) restart = 1'b1;
        endcase
        if (restart) begin
            nxt = 0;
            if (m_relock < 255) m_relock++;
        end
        if (nxt != old) begin
            m_tin = 0; m_streak = 0; m_wt = 0;
        end
        stay = (old == 3) && (nxt == 3);
        m_k  = stay ? m_k + 1 : 0;
        for (int i = 0; i < NUM_CH; i++) begin
            sh_old  = m_sh[i];
            m_ce[i] = 1'b0;
            if (m_p[i] == 0) begin
                m_p[i]    = sh_old;
                m_base[i] = m_k;
            end else if (stay && (m_k == m_base[i] + m_p[i])) begin
                m_ce[i]   = 1'b1;
                m_base[i] = m_k;
                m_p[i]    = sh_old;
            end
            if (!stay) m_base[i] = 0;
            if (div_load) m_sh[i] = int'(div[i*DIV_W +: DIV_W]);
        end
        m_mode = nxt;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) m_reset();
            else m_step();
        end
    end

    initial begin
        logic [14:0] mexp;
        forever begin
            @(negedge clk);
            mexp = {m_mode[1:0], (m_mode == 0), (m_mode == 3), (m_mode == 3), m_ce, m_relock[7:0]};
            chk("model", obs, mexp);
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        int         ncyc;
        logic       lock;
        logic       relock;
        logic [1:0] st;
        logic       prst;
        logic       srstn;
        logic       rdy;
        logic [7:0] rc;
    } vec_t;

    function automatic vec_t mk(int n, logic l, logic r, logic [1:0] s, logic p,
                                logic sr, logic rd, logic [7:0] rc);
        vec_t v;
        v.ncyc = n; v.lock = l; v.relock = r; v.st = s;
        v.prst = p; v.srstn = sr; v.rdy = rd; v.rc = rc;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        vec_t v;
        bit   found;
        logic [1:0] ce_exp;

        reset_n = 1'b0; pll_lock = 1'b1; sw_relock = 1'b0; div_load = 1'b0; div = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", obs, {2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0});
        reset_n = 1'b1;

        // bring-up with lock held high
        tbl.push_back(mk(3, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 8'd0));
        tbl.push_back(mk(1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0));
        tbl.push_back(mk(7, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0));
        tbl.push_back(mk(1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 8'd0));
        tbl.push_back(mk(3, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 8'd0));
        tbl.push_back(mk(1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 8'd0));
        // sw_relock in RUN restarts, a second one in PLL_RST is ignored
        tbl.push_back(mk(1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 8'd1));
        tbl.push_back(mk(1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 8'd1));
        tbl.push_back(mk(2, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 8'd1));
        tbl.push_back(mk(1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd1));
        // one-cycle lock glitch after 6 high samples restarts the filter
        tbl.push_back(mk(4, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd1));
        tbl.push_back(mk(1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd1));
        tbl.push_back(mk(1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd1));
        tbl.push_back(mk(1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd1));
        tbl.push_back(mk(7, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd1));
        tbl.push_back(mk(1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 8'd1));
        tbl.push_back(mk(3, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 8'd1));
        tbl.push_back(mk(1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 8'd1));
        // lock loss in RUN reacts 3 cycles later, then full bring-up again
        tbl.push_back(mk(2, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 8'd1));
        tbl.push_back(mk(1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 8'd2));
        tbl.push_back(mk(3, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 8'd2));
        tbl.push_back(mk(1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd2));
        tbl.push_back(mk(7, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd2));
        tbl.push_back(mk(1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 8'd2));
        tbl.push_back(mk(3, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 8'd2));
        tbl.push_back(mk(1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 8'd2));

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            pll_lock  = v.lock;
            sw_relock = v.relock;
            repeat (v.ncyc) begin
                @(negedge clk);
                sw_relock = 1'b0;
            end
            chk($sformatf("vec%0d", i), obs, {v.st, v.prst, v.srstn, v.rdy, 2'b00, v.rc});
        end

        // dividers: ch0=3, ch1=0 loaded before RUN; ch0 reloaded to 5 mid-period
        sw_relock = 1'b1;
        @(negedge clk);
        sw_relock = 1'b0;
        chk("sw_relock_cnt", relock_cnt, 32'd3);
        div = {8'd0, 8'd3}; div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 100 && !found; t++) begin
            @(negedge clk);
            if (state == 2'd3) found = 1'b1;
        end
        chk("run_reached", found, 32'd1);
        for (int k = 0; k <= 14; k++) begin
            ce_exp = (k == 3 || k == 6 || k == 9 || k == 14) ? 2'b01 : 2'b00;
            chk($sformatf("ce_k%0d", k), ce, ce_exp);
            if (k == 7) begin
                div = {8'd0, 8'd5}; div_load = 1'b1;
            end else begin
                div_load = 1'b0;
            end
            if (k < 14) @(negedge clk);
        end

        // lock held low: timeout loop with the macro, stuck in WAIT_LOCK without it
        pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        chk("tmo_loss_state", state, 32'd0);
        chk("tmo_loss_rc", relock_cnt, 32'd4);
        chk("tmo_loss_ce", ce, 32'd0);
        repeat (4) @(negedge clk);
        chk("tmo_wait_state", state, 32'd1);
`ifdef CLKSEQ_TIMEOUT_EN
        repeat (63) @(negedge clk);
        chk("tmo_last_wait", state, 32'd1);
        @(negedge clk);
        chk("tmo_restart", state, 32'd0);
        chk("tmo_rc", relock_cnt, 32'd5);
        repeat (260 * 68) @(negedge clk);
        chk("tmo_saturate", relock_cnt, 32'd255);
`else
        repeat (200) @(negedge clk);
        chk("no_tmo_state", state, 32'd1);
        chk("no_tmo_rc", relock_cnt, 32'd4);
`endif

        // asynchronous reset mid-cycle forces reset values at once
        pll_lock = 1'b1;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk("async_reset", obs, {2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0});
        @(negedge clk);
        reset_n = 1'b1;

        // randomized traffic against the model
        repeat (3000) begin
            @(negedge clk);
            pll_lock  = ($urandom_range(0, 99) < 97);
            sw_relock = ($urandom_range(0, 199) == 0);
            div_load  = ($urandom_range(0, 29) == 0);
            for (int i = 0; i < NUM_CH; i++) begin
                div[i*DIV_W +: DIV_W] = 8'($urandom_range(0, 5));
            end
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
